// File: rtl/halo_exchange_ctrl.sv
// Per-tile halo exchange sequencer: compute wait, neighbor clear-to-send handshake,
// row-major halo coordinate stream, neighbor completion sync and a completion pulse.
module halo_exchange_ctrl #(
    parameter int TILE_SIZE = 128,
    localparam int CW = $clog2(TILE_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    kernel_size,
    input  logic          cycle_done,
    input  logic [7:0]    neighbor_present,
    input  logic [7:0]    neighbor_cts,
    input  logic [7:0]    neighbor_exchange_done,
    input  logic          halo_ready,
    output logic          busy,
    output logic          clear_to_send,
    output logic          halo_valid,
    output logic [CW-1:0] halo_row,
    output logic [CW-1:0] halo_column,
    output logic          exchange_done,
    output logic          channel_group_done,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPUTE   = 3'd1,
        HANDSHAKE = 3'd2,
        SEND      = 3'd3,
        SYNC      = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(TILE_SIZE - 1);

    state_t      state;
    logic [2:0]  halo_width;
    logic [CW-1:0] h_cw;
    logic [CW-1:0] hi_start;
    logic        interior_row;
    logic        last_coord;
    logic        all_cts;
    logic        all_done;

    // Absent neighbors never hold up the handshake or the completion sync.
    assign all_cts  = &(neighbor_cts | ~neighbor_present);
    assign all_done = &(neighbor_exchange_done | ~neighbor_present);

    // hi_start = TILE_SIZE - H, formed without ever reaching TILE_SIZE (only used when H > 0).
    assign h_cw         = CW'(halo_width);
    assign hi_start     = LAST - h_cw + CW'(1);
    assign interior_row = (halo_row >= h_cw) && (halo_row < hi_start);
    assign last_coord   = (halo_row == LAST) && (halo_column == LAST);

    assign state_dbg = state;

    // halo_valid/halo_ready: a coordinate transfers on a rising edge where both are high;
    // while halo_ready is low, halo_valid and the coordinate hold unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            halo_width         <= '0;
            busy               <= 1'b0;
            clear_to_send      <= 1'b0;
            halo_valid         <= 1'b0;
            halo_row           <= '0;
            halo_column        <= '0;
            exchange_done      <= 1'b0;
            channel_group_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= COMPUTE;
                        busy       <= 1'b1;
                        halo_width <= kernel_size >> 1;
                    end
                end
                COMPUTE: begin
                    if (cycle_done) begin
                        state         <= HANDSHAKE;
                        clear_to_send <= 1'b1;
                    end
                end
                HANDSHAKE: begin
                    if (all_cts) begin
                        if (halo_width != 3'd0) begin
                            state       <= SEND;
                            halo_valid  <= 1'b1;
                            halo_row    <= '0;
                            halo_column <= '0;
                        end else begin
                            state         <= SYNC;
                            exchange_done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (halo_valid && halo_ready) begin
                        if (last_coord) begin
                            state         <= SYNC;
                            halo_valid    <= 1'b0;
                            exchange_done <= 1'b1;
                            halo_row      <= '0;
                            halo_column   <= '0;
                        end else if (halo_column == LAST) begin
                            halo_column <= '0;
                            halo_row    <= halo_row + CW'(1);
                        end else if (interior_row && (halo_column == h_cw - CW'(1))) begin
                            halo_column <= hi_start;
                        end else begin
                            halo_column <= halo_column + CW'(1);
                        end
                    end
                end
                SYNC: begin
                    if (all_done) begin
                        state              <= DONE;
                        channel_group_done <= 1'b1;
                        exchange_done      <= 1'b0;
                        clear_to_send      <= 1'b0;
                    end
                end
                DONE: begin
                    state              <= IDLE;
                    channel_group_done <= 1'b0;
                    busy               <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halo_exchange_ctrl.sv
// Randomized bench for halo_exchange_ctrl: channel groups with varied kernel sizes,
// neighbor masks and backpressure, checked against an expected coordinate queue.
module tb_halo_exchange_ctrl;

    localparam int T  = 8;
    localparam int CW = $clog2(T);
    localparam int W  = 2 * CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    kernel_size;
    logic          cycle_done;
    logic [7:0]    neighbor_present;
    logic [7:0]    neighbor_cts;
    logic [7:0]    neighbor_exchange_done;
    logic          halo_ready;
    logic          busy;
    logic          clear_to_send;
    logic          halo_valid;
    logic [CW-1:0] halo_row;
    logic [CW-1:0] halo_column;
    logic          exchange_done;
    logic          channel_group_done;
    logic [2:0]    state_dbg;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    halo_exchange_ctrl #(.TILE_SIZE(T)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .kernel_size            (kernel_size),
        .cycle_done             (cycle_done),
        .neighbor_present       (neighbor_present),
        .neighbor_cts           (neighbor_cts),
        .neighbor_exchange_done (neighbor_exchange_done),
        .halo_ready             (halo_ready),
        .busy                   (busy),
        .clear_to_send          (clear_to_send),
        .halo_valid             (halo_valid),
        .halo_row               (halo_row),
        .halo_column            (halo_column),
        .exchange_done          (exchange_done),
        .channel_group_done     (channel_group_done),
        .state_dbg              (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every tile coordinate lying within H of any edge, in row-major order.
    task automatic build_exp(input int h);
        logic [CW-1:0] rr, cc;
        exp_q.delete();
        for (int r = 0; r < T; r++) begin
            for (int c = 0; c < T; c++) begin
                if (r < h || r >= T - h || c < h || c >= T - h) begin
                    rr = r[CW-1:0];
                    cc = c[CW-1:0];
                    exp_q.push_back({rr, cc});
                end
            end
        end
    endtask

    function automatic logic [7:0] add_missing(input logic [7:0] present, input logic [7:0] val);
        int k;
        k = $urandom_range(0, 7);
        for (int j = 0; j < 8; j++) begin
            if (present[(k + j) % 8] && !val[(k + j) % 8]) return val | (8'h1 << ((k + j) % 8));
        end
        return val;
    endfunction

    // Waits for all present bits of cts (sel=0) or exchange_done (sel=1); bits rise one at a time.
    task automatic neighbor_wait(input bit sel, input logic [7:0] present, output bit ok);
        logic [7:0] v;
        bit all_now;
        v = ($urandom_range(0, 1) == 1) ? 8'hFF : (8'($urandom) & ~present);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            v = (v & present) | (8'($urandom) & ~present);
            if (sel) neighbor_exchange_done = v; else neighbor_cts = v;
            if (sel) cycle_done = 1'($urandom_range(0, 1));
            all_now = ((v | ~present) == 8'hFF);
            tick();
            if (all_now) begin
                ok = 1'b1;
                return;
            end
            check(sel ? "sync_hold_ed" : "hs_hold_valid", sel ? exchange_done : halo_valid, sel ? 1 : 0);
            check(sel ? "sync_hold_pulse" : "hs_hold_ed", sel ? channel_group_done : exchange_done, 0);
            check("wait_cts_high", clear_to_send, 1);
            check("wait_busy", busy, 1);
            if ($urandom_range(0, 2) != 0) v = add_missing(present, v);
        end
        check(sel ? "sync_timeout" : "hs_timeout", 0, 1);
    endtask

    // driver: one channel group; abort_at >= 0 asserts reset after that many transfers
    task automatic run_group(input int kern, input logic [7:0] present, input bit rand_ready,
                             input int abort_at);
        int h, hs, cyc, exp_count;
        bit ok;
        h = kern >> 1;
        exp_count = T * T - (T - 2 * h) * (T - 2 * h);
        build_exp(h);
        neighbor_present = present;
        neighbor_cts = 8'h00;
        neighbor_exchange_done = 8'h00;
        halo_ready = 1'b0;
        kernel_size = 3'(kern);
        check("idle_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("compute_cts", clear_to_send, 0);
        repeat ($urandom_range(0, 3)) begin
            tick();
            check("compute_cts_low", clear_to_send, 0);
        end
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        check("cts_after_done", clear_to_send, 1);
        check("cts_no_valid", halo_valid, 0);

        neighbor_wait(1'b0, present, ok);
        if (!ok) return;
        if (h > 0) begin
            check("send_entry_valid", halo_valid, 1);
            check("send_entry_ed", exchange_done, 0);
        end else begin
            check("h0_no_valid", halo_valid, 0);
            check("h0_ed", exchange_done, 1);
        end

        hs = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            check("send_valid", halo_valid, 1);
            check("send_coord", {halo_row, halo_column}, exp_q[0]);
            check("send_ed_low", exchange_done, 0);
            if (hs == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_busy", busy, 0);
                check("abort_cts", clear_to_send, 0);
                check("abort_valid", halo_valid, 0);
                check("abort_coord", {halo_row, halo_column}, 0);
                check("abort_ed", exchange_done, 0);
                check("abort_pulse", channel_group_done, 0);
                tick();
                reset = 1'b0;
                start = 1'b0;
                halo_ready = 1'b0;
                tick();
                check("abort_pulse_after", channel_group_done, 0);
                check("abort_idle_busy", busy, 0);
                return;
            end
            halo_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'($urandom_range(0, 1));
            if (halo_ready) begin
                void'(exp_q.pop_front());
                hs++;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("send_all_emitted", exp_q.size(), 0);
        check("send_count", hs, exp_count);
        if (!rand_ready) check("send_throughput", cyc, exp_count);
        check("sync_valid_low", halo_valid, 0);
        check("sync_ed", exchange_done, 1);

        neighbor_wait(1'b1, present, ok);
        if (!ok) return;
        cycle_done = 1'b0;
        check("pulse_high", channel_group_done, 1);
        check("pulse_ed_low", exchange_done, 0);
        check("pulse_cts_low", clear_to_send, 0);
        check("pulse_busy", busy, 1);
        neighbor_cts = 8'h00;
        neighbor_exchange_done = 8'h00;
        tick();
        check("pulse_single", channel_group_done, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        kernel_size = 3'd0;
        cycle_done = 1'b0;
        neighbor_present = 8'h00;
        neighbor_cts = 8'h00;
        neighbor_exchange_done = 8'h00;
        halo_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_cts", clear_to_send, 0);
        check("rst_valid", halo_valid, 0);
        check("rst_coord", {halo_row, halo_column}, 0);
        check("rst_ed", exchange_done, 0);
        check("rst_pulse", channel_group_done, 0);
        reset = 1'b0;
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        check("idle_ignores_cycle_done", busy, 0);

        run_group(3, 8'hFF, 1'b0, -1);
        run_group(7, 8'hFF, 1'b0, -1);
        run_group(5, 8'h0F, 1'b1, -1);
        run_group(1, 8'hA5, 1'b1, -1);
        run_group(0, 8'h00, 1'b0, -1);
        run_group(2, 8'h00, 1'b1, -1);
        run_group(3, 8'hFF, 1'b1, 10);
        run_group(3, 8'hFF, 1'b1, -1);
        for (int n = 0; n < 8; n++) begin
            run_group(int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
